// File: rtl/game_pkg.sv
// Shared game state encoding and default playfield geometry for the
// flappy-style game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        HIT   = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam int DEF_BIRD_X       = 100;
    localparam int DEF_BIRD_W       = 34;
    localparam int DEF_BIRD_H       = 24;
    localparam int DEF_OBST_W       = 60;
    localparam int DEF_SCREEN_H     = 600;
    localparam int DEF_READY_FRAMES = 60;
    localparam int DEF_HIT_FRAMES   = 30;

    localparam int CNT_W = 16;

endpackage

// File: rtl/game_score_bcd.sv
// Three-digit BCD score counter: synchronous clear, increment with full
// carry ripple in one cycle, saturating at 999.
module game_score_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] score
);

    logic [11:0] r_score;
    logic [3:0]  w_u;
    logic [3:0]  w_t;
    logic [3:0]  w_h;

    always_comb begin
        w_u = r_score[3:0];
        w_t = r_score[7:4];
        w_h = r_score[11:8];
        if (r_score != 12'h999) begin
            if (w_u == 4'd9) begin
                w_u = 4'd0;
                if (w_t == 4'd9) begin
                    w_t = 4'd0;
                    w_h = w_h + 4'd1;
                end else begin
                    w_t = w_t + 4'd1;
                end
            end else begin
                w_u = w_u + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score <= 12'h000;
        end else if (clr) begin
            r_score <= 12'h000;
        end else if (inc) begin
            r_score <= {w_h, w_t, w_u};
        end
    end

    assign score = r_score;

endmodule

// File: rtl/game_ctl.sv
// Game sequencer: button/vsync conditioning, per-frame position snapshot,
// collision and pass detection, and the IDLE/READY/PLAY/HIT/OVER machine.
module game_ctl
    import game_pkg::*;
#(
    parameter int BIRD_X       = DEF_BIRD_X,
    parameter int BIRD_W       = DEF_BIRD_W,
    parameter int BIRD_H       = DEF_BIRD_H,
    parameter int OBST_W       = DEF_OBST_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int READY_FRAMES = DEF_READY_FRAMES,
    parameter int HIT_FRAMES   = DEF_HIT_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        left,
    input  logic        right,
    input  logic [11:0] bird_ypos,
    input  logic [11:0] obst_xpos,
    input  logic [11:0] gap_top,
    input  logic [11:0] gap_bot,
    output logic [2:0]  state,
    output logic        run,
    output logic        flap,
    output logic        frame_tick,
    output logic        endgame,
    output logic [11:0] score
);

    localparam logic [12:0] C_BIRD_X  = 13'(BIRD_X);
    localparam logic [12:0] C_BIRD_XR = 13'(BIRD_X + BIRD_W);
    localparam logic [12:0] C_BIRD_H  = 13'(BIRD_H);
    localparam logic [12:0] C_OBST_W  = 13'(OBST_W);
    localparam logic [12:0] C_FLOOR   = 13'(SCREEN_H);

    logic r_left_s1, r_left_s2, r_left_d, r_left_edge;
    logic r_right_s1, r_right_s2, r_right_d, r_right_edge;
    logic r_vs_1, r_vs_2, r_tick, r_tick_d;

    logic [11:0] r_bird_y, r_obst_x, r_prev_x, r_gap_top, r_gap_bot;

    game_state_t      r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_run, r_flap, r_endgame;
    logic             w_clr, w_inc;

    logic [12:0] w_bird_bot, w_obst_r, w_prev_r;
    logic        w_ceil, w_floor, w_xov, w_pipe, w_hit, w_pass, w_cnt_done;

    // Input conditioning: buttons cross from the mouse domain, vsync is local.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_left_s1    <= 1'b0;
            r_left_s2    <= 1'b0;
            r_left_d     <= 1'b0;
            r_left_edge  <= 1'b0;
            r_right_s1   <= 1'b0;
            r_right_s2   <= 1'b0;
            r_right_d    <= 1'b0;
            r_right_edge <= 1'b0;
            r_vs_1       <= 1'b0;
            r_vs_2       <= 1'b0;
            r_tick       <= 1'b0;
            r_tick_d     <= 1'b0;
        end else begin
            r_left_s1    <= left;
            r_left_s2    <= r_left_s1;
            r_left_d     <= r_left_s2;
            r_left_edge  <= r_left_s2 & ~r_left_d;
            r_right_s1   <= right;
            r_right_s2   <= r_right_s1;
            r_right_d    <= r_right_s2;
            r_right_edge <= r_right_s2 & ~r_right_d;
            r_vs_1       <= vsync;
            r_vs_2       <= r_vs_1;
            r_tick       <= r_vs_1 & ~r_vs_2;
            r_tick_d     <= r_tick;
        end
    end

    // Snapshot stage: positions frozen once per frame; previous obstacle x kept for pass detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bird_y  <= 12'd0;
            r_obst_x  <= 12'd0;
            r_prev_x  <= 12'd0;
            r_gap_top <= 12'd0;
            r_gap_bot <= 12'd0;
        end else if (r_tick) begin
            r_bird_y  <= bird_ypos;
            r_obst_x  <= obst_xpos;
            r_prev_x  <= r_obst_x;
            r_gap_top <= gap_top;
            r_gap_bot <= gap_bot;
        end
    end

    always_comb begin
        w_bird_bot = {1'b0, r_bird_y} + C_BIRD_H;
        w_obst_r   = {1'b0, r_obst_x} + C_OBST_W;
        w_prev_r   = {1'b0, r_prev_x} + C_OBST_W;
        w_ceil     = (r_bird_y == 12'd0);
        w_floor    = (w_bird_bot >= C_FLOOR);
        w_xov      = ({1'b0, r_obst_x} < C_BIRD_XR) && (w_obst_r > C_BIRD_X);
        w_pipe     = w_xov && (({1'b0, r_bird_y} < {1'b0, r_gap_top}) ||
                               (w_bird_bot > {1'b0, r_gap_bot}));
        w_hit      = w_ceil || w_floor || w_pipe;
        // A respawn moves the obstacle right, so require strictly decreasing x.
        w_pass     = (w_prev_r >= C_BIRD_X) && (w_obst_r < C_BIRD_X) &&
                     (r_obst_x < r_prev_x);
        w_cnt_done = (r_cnt <= CNT_W'(1));
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_left_edge) begin
                    w_state_next = READY;
                    w_cnt_next   = CNT_W'(READY_FRAMES);
                    w_clr        = 1'b1;
                end
            end
            READY: begin
                if (r_tick_d) begin
                    if (w_cnt_done) w_state_next = PLAY;
                    else            w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            PLAY: begin
                if (r_tick_d) begin
                    if (w_hit) begin
                        w_state_next = HIT;
                        w_cnt_next   = CNT_W'(HIT_FRAMES);
                    end else begin
                        w_inc = w_pass;
                    end
                end
            end
            HIT: begin
                if (r_tick_d) begin
                    if (w_cnt_done) w_state_next = OVER;
                    else            w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            OVER: begin
                if (r_right_edge) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State/output stage: everything leaving the block comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_flap    <= 1'b0;
            r_endgame <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_run     <= (w_state_next == PLAY);
            r_flap    <= (r_state == PLAY) && r_left_edge;
            r_endgame <= (w_state_next == OVER);
        end
    end

    game_score_bcd u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_inc),
        .score (score)
    );

    assign state      = r_state;
    assign run        = r_run;
    assign flap       = r_flap;
    assign frame_tick = r_tick;
    assign endgame    = r_endgame;

endmodule

// File: doc/game_ctl.md
# game_ctl

Game sequencer for the VGA flappy-style game in the 40 MHz pixel domain. It owns the game state: idle, countdown, play, hit-freeze and game over.
- Samples player and obstacle positions once per frame and detects collisions.
- Counts the score in BCD and issues a one-cycle flap pulse to the player controller.
- Drives `run` and `endgame` for the obstacle controller and the text overlay.

## Interface
Parameters
- BIRD_X, 100: fixed left x of the player sprite.
- BIRD_W, 34: player width in pixels.
- BIRD_H, 24: player height in pixels.
- OBST_W, 60: obstacle column width in pixels.
- SCREEN_H, 600: visible lines; the floor is at this line.
- READY_FRAMES, 60: countdown length in frames.
- HIT_FRAMES, 30: freeze length after a collision, in frames.

Ports
- clk  in  1  40 MHz pixel clock; the block's only clock.
- rst  in  1  asynchronous reset, active-low.
- vsync  in  1  vertical sync from the timing chain, active high.
- left  in  1  mouse left button, 100 MHz domain; flap/start.
- right  in  1  mouse right button, 100 MHz domain; restart.
- bird_ypos  in  12  player top y.
- obst_xpos  in  12  obstacle left x.
- gap_top  in  12  first line of the obstacle gap.
- gap_bot  in  12  first line below the obstacle gap.
- state  out  3  current state, `game_state_t`.
- run  out  1  high in PLAY only; enables obstacle/player motion.
- flap  out  1  one-cycle flap pulse.
- frame_tick  out  1  one-cycle pulse per frame.
- endgame  out  1  high in OVER.
- score  out  12  3-digit BCD score: [11:8] hundreds, [7:4] tens, [3:0] units.

## Operation
- `left` and `right` pass through 2-FF synchronizers, then a registered edge detector. Only 0→1 edges act.
- `frame_tick` is the registered rising edge of `vsync`.
- On each tick, `bird_ypos`, `obst_xpos`, `gap_top` and `gap_bot` are captured into snapshot registers. All checks use the snapshot.
- All sums (e.g. `bird_ypos+BIRD_H`) are computed 13 bits wide and compared unsigned.
- Collision is the OR of three conditions:
  - Ceiling: bird_y == 0.
  - Floor: bird_y+BIRD_H ≥ SCREEN_H.
  - Pipe: x overlap with the obstacle (obst_x < BIRD_X+BIRD_W and obst_x+OBST_W > BIRD_X) AND (bird_y < gap_top or bird_y+BIRD_H > gap_bot).
- Pass detection:
  - A pass is prev snapshot obst_x+OBST_W ≥ BIRD_X and current obst_x+OBST_W < BIRD_X.
  - An increasing obst_x (obstacle respawn) never scores.
- State machine:
  - IDLE → READY on a left edge. The down-counter loads READY_FRAMES and the score clears to 0.
  - READY: the counter decrements on each tick. At 0, go to PLAY on that tick.
  - PLAY: `run`=1, and each left edge gives `flap`=1 for one cycle. On each tick:
    - Collision → HIT; the counter loads HIT_FRAMES.
    - Otherwise a pass increments the score.
  - HIT: `run`=0. The counter decrements per tick; at 0 go to OVER.
  - OVER: `endgame`=1 and the score is held. A right edge → IDLE.
- Boundaries:
  - Collision and pass on the same tick: collision wins and the score is unchanged.
  - Score saturates at 999 (12'h999).
  - BCD carries ripple within one cycle.
  - Left edge in the same cycle as a tick in PLAY: the flap is still issued.
  - Left in HIT/OVER and right in IDLE/READY/PLAY/HIT are ignored.
  - A button held across the OVER→IDLE→READY path needs a fresh edge.
  - READY_FRAMES=0 or HIT_FRAMES=0: the transition happens on the first tick.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state=IDLE and score=0.
  - run, flap, frame_tick and endgame all 0.
  - Counters, synchronizers and snapshots cleared.
- `frame_tick` rises 2 cycles after `vsync` rises at the input.
- Snapshot is valid 1 cycle after `frame_tick`.
- State and score update 2 cycles after `frame_tick`.
- `flap` occurs 4 cycles after a `left` rise at the input: 2 synchronizer cycles + edge register + output register.
- All outputs are registered.

## Structure
- `game_pkg` holds `game_state_t` (IDLE, READY, PLAY, HIT, OVER; 3-bit) and the default geometry constants.
- Sub-module `game_score_bcd`: 3-digit saturating BCD counter with `clr` and `inc` inputs.

## Test plan
- Reset mid-PLAY with score 12'h042 → next cycle state=IDLE, score=0, run=0, endgame=0.
- Left edge in IDLE, READY_FRAMES=3 → READY, then PLAY on the 3rd tick; run=1 from then on.
- PLAY, bird_ypos=300, gap 250..400, obst_xpos walked 200→39 in steps of 1 per frame → score=12'h001 once; respawn to 800 leaves score unchanged.
- PLAY, bird_ypos=200, gap_top=250, obst_xpos=110 on a tick → HIT; after HIT_FRAMES ticks → OVER, endgame=1; right edge → IDLE.
- Collision and pass on the same tick → HIT, score unchanged. Score preset to 999 plus a pass → stays 12'h999.
- Left pulse during PLAY → exactly one `flap` cycle, 4 cycles after the input rise. Left held for 10 frames → one flap only.
